// File: rtl/bp_table_ctrl.sv
// Pattern-history-table controller: 2^IDX_W two-bit counters, one table access per
// cycle shared between fetch lookups and FIFO-buffered resolved-branch updates.
// Define GSHARE_EN to hash the index with a global history register.
module bp_table_ctrl #(
    parameter int IDX_W      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_pc,
    input  logic             upd_taken,
    output logic             busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TBL_N = 1 << IDX_W;

    typedef enum logic [1:0] {GNT_IDLE, GNT_LOOKUP, GNT_DRAIN} grant_e;

    logic [1:0]       table_q [TBL_N];
    logic [IDX_W-1:0] fifo_pc_q [FIFO_DEPTH];
    logic             fifo_taken_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;

    grant_e           grant;
    logic             full, empty, push, pop;
    logic [IDX_W-1:0] head_pc, lookup_idx, drain_idx;
    logic             head_taken;
    logic [1:0]       drain_cur, drain_new;

    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign head_pc    = fifo_pc_q[rd_ptr_q];
    assign head_taken = fifo_taken_q[rd_ptr_q];

`ifdef GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    assign lookup_idx = req_pc ^ ghr_q;
    assign drain_idx  = head_pc ^ ghr_q;
    assign ghr_d      = pop ? {ghr_q[IDX_W-2:0], head_taken} : ghr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end
`else
    assign lookup_idx = req_pc;
    assign drain_idx  = head_pc;
`endif

    // A full FIFO wins over lookups so updates cannot starve behind continuous fetch.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant = GNT_IDLE;
        if (full)           grant = GNT_DRAIN;
        else if (req_valid) grant = GNT_LOOKUP;
        else if (!empty)    grant = GNT_DRAIN;
    end

    assign push = upd_valid && !full;
    assign pop  = (grant == GNT_DRAIN);

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        pred_valid_d = (grant == GNT_LOOKUP);
        pred_taken_d = (grant == GNT_LOOKUP) ? table_q[lookup_idx][1] : pred_taken_q;
    end

    always_comb begin
        drain_cur = table_q[drain_idx];
        drain_new = drain_cur;
        if (head_taken && drain_cur != 2'b11)      drain_new = drain_cur + 2'b01;
        else if (!head_taken && drain_cur != 2'b00) drain_new = drain_cur - 2'b01;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter table is reset because its contents are architectural
            // (strongly taken); the FIFO payload below is not, since count_q alone
            // decides which entries are live.
            for (int i = 0; i < TBL_N; i++) table_q[i] <= 2'b11;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            if (pop) table_q[drain_idx] <= drain_new;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= upd_pc;
            fifo_taken_q[wr_ptr_q] <= upd_taken;
        end
    end

    assign req_ready  = !full;
    assign upd_ready  = !full;
    assign busy       = !empty;
    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;

endmodule
